// File: rtl/tdm_rx.sv
// tdm_rx: serial TDM PCM receiver. Deserializes NCH slots of W-bit words,
// checks frame alignment against the frame sync, and hands each completed
// word (tagged with its slot number) to a 2-entry valid/ready buffer.
module tdm_rx #(
  parameter int NCH = 32,
  parameter int W   = 8,
  localparam int CHW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tdm_ben,
  input  logic           tdm_din,
  input  logic           tdm_fs,
  input  logic           pcm_ready,
  input  logic           err_clr,
  output logic           pcm_valid,
  output logic [W-1:0]   pcm_data,
  output logic [CHW-1:0] pcm_chan,
  output logic           frame_err,
  output logic           ovf,
  input  logic           scan_in0,
  input  logic           scan_in1,
  input  logic           scan_in2,
  input  logic           scan_in3,
  input  logic           scan_in4,
  input  logic           scan_enable,
  input  logic           test_mode,
  output logic           scan_out0,
  output logic           scan_out1,
  output logic           scan_out2,
  output logic           scan_out3,
  output logic           scan_out4
);

  localparam int BW = $clog2(W);
  localparam logic [BW-1:0]  LAST_BIT  = BW'(W - 1);
  localparam logic [CHW-1:0] LAST_SLOT = CHW'(NCH - 1);

  typedef enum logic {HUNT, RUN} state_t;

  state_t         state;
  logic [BW-1:0]  bit_cnt;
  logic [CHW-1:0] slot_cnt;
  logic [W-2:0]   sr;

  logic           at_fs_pos;
  logic           push;
  logic           ferr_set;
  logic [W-1:0]   push_word;

  logic [W-1:0]   mem_data [2];
  logic [CHW-1:0] mem_chan [2];
  logic           wr_ptr;
  logic           rd_ptr;
  logic [1:0]     count;
  logic           pop;
  logic           full;
  logic           accept;
  logic           ovf_set;

  // Scan chain is stitched in by DFT insertion; mission mode drives zeros.
  logic unused_scan;
  assign unused_scan = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                         scan_enable, test_mode};
  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  assign at_fs_pos = (bit_cnt == '0) && (slot_cnt == '0);
  assign push_word = {sr, tdm_din};

  // Classify the current bit event: word completion or alignment error.
  always_comb begin
    push     = 1'b0;
    ferr_set = 1'b0;
    if (tdm_ben && state == RUN) begin
      if (at_fs_pos) begin
        ferr_set = !tdm_fs;
      end else if (tdm_fs) begin
        ferr_set = 1'b1;
      end else if (bit_cnt == LAST_BIT) begin
        push = 1'b1;
      end
    end
  end

  // Framing FSM: hunt for frame sync, then track bit and slot position.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= HUNT;
      bit_cnt  <= '0;
      slot_cnt <= '0;
    end else if (tdm_ben) begin
      case (state)
        HUNT: begin
          if (tdm_fs) begin
            state    <= RUN;
            bit_cnt  <= BW'(1);
            slot_cnt <= '0;
          end
        end
        RUN: begin
          if (at_fs_pos && !tdm_fs) begin
            state    <= HUNT;
            bit_cnt  <= '0;
            slot_cnt <= '0;
          end else if (!at_fs_pos && tdm_fs) begin
            // Misplaced sync: this bit restarts the frame as slot 0 MSB.
            bit_cnt  <= BW'(1);
            slot_cnt <= '0;
          end else if (bit_cnt == LAST_BIT) begin
            bit_cnt  <= '0;
            slot_cnt <= (slot_cnt == LAST_SLOT) ? '0 : slot_cnt + CHW'(1);
          end else begin
            bit_cnt  <= bit_cnt + BW'(1);
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  // Shift register always keeps the most recent W-1 bits; after a (re)start
  // the stale bits are shifted out before the word completes.
  always_ff @(posedge clk) begin
    if (tdm_ben) sr <= {sr[W-3:0], tdm_din};
  end

  assign pcm_valid = (count != 2'd0);
  assign pop       = pcm_valid && pcm_ready;
  assign full      = (count == 2'd2);
  assign accept    = push && (!full || pop);
  assign ovf_set   = push && full && !pop;
  assign pcm_data  = pcm_valid ? mem_data[rd_ptr] : '0;
  assign pcm_chan  = pcm_valid ? mem_chan[rd_ptr] : '0;

  // Buffer pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (accept) wr_ptr <= ~wr_ptr;
      if (pop)    rd_ptr <= ~rd_ptr;
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Buffer storage; when full with a pop, the write lands in the slot being
  // read out this cycle, so ordering is preserved.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_data[wr_ptr] <= push_word;
      mem_chan[wr_ptr] <= slot_cnt;
    end
  end

  // Sticky error flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (ferr_set)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (ovf_set)      ovf <= 1'b1;
      else if (err_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdm_rx.sv
// tb_tdm_rx: randomized and directed stimulus for tdm_rx, checked every
// cycle against a frame-position / word-queue reference model.
module tb_tdm_rx;

  localparam int NCH = 32;
  localparam int W   = 8;
  localparam int CHW = 5;

  logic clk = 1'b0;
  logic reset;
  logic tdm_ben, tdm_din, tdm_fs, pcm_ready, err_clr;
  logic pcm_valid;
  logic [W-1:0] pcm_data;
  logic [CHW-1:0] pcm_chan;
  logic frame_err, ovf;
  logic scan_in0, scan_in1, scan_in2, scan_in3, scan_in4, scan_enable, test_mode;
  logic scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

  always #5 clk = ~clk;

  tdm_rx #(.NCH(NCH), .W(W)) dut (
    .clk(clk), .reset(reset), .tdm_ben(tdm_ben), .tdm_din(tdm_din),
    .tdm_fs(tdm_fs), .pcm_ready(pcm_ready), .err_clr(err_clr),
    .pcm_valid(pcm_valid), .pcm_data(pcm_data), .pcm_chan(pcm_chan),
    .frame_err(frame_err), .ovf(ovf),
    .scan_in0(scan_in0), .scan_in1(scan_in1), .scan_in2(scan_in2),
    .scan_in3(scan_in3), .scan_in4(scan_in4), .scan_enable(scan_enable),
    .test_mode(test_mode),
    .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2),
    .scan_out3(scan_out3), .scan_out4(scan_out4)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int pops   = 0;
  int rdy_mode = 0;   // 0: always ready, 1: never ready, 2: random
  int gap_max  = 0;

  // Reference model: frame position 0..NCH*W-1 and a bounded word queue.
  bit m_sync;
  int m_pos;
  int m_word;
  int q_data[$];
  int q_chan[$];
  bit m_ferr, m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_sync = 0; m_pos = 0; m_word = 0;
    q_data.delete(); q_chan.delete();
    m_ferr = 0; m_ovf = 0;
  endtask

  task automatic model_update(input logic ben, din, fs, rdy, clr);
    bit eset, oset, psh;
    int pw, pc;
    eset = 0; oset = 0; psh = 0; pw = 0; pc = 0;
    if (ben) begin
      if (!m_sync) begin
        if (fs) begin m_sync = 1; m_word = int'(din); m_pos = 1; end
      end else if (m_pos == 0) begin
        if (fs) begin m_word = int'(din); m_pos = 1; end
        else begin eset = 1; m_sync = 0; end
      end else if (fs) begin
        eset = 1; m_word = int'(din); m_pos = 1;
      end else begin
        m_word = ((m_word << 1) | int'(din)) & 'hFF;
        if (m_pos % W == W - 1) begin psh = 1; pw = m_word; pc = m_pos / W; end
        m_pos = (m_pos + 1) % (NCH * W);
      end
    end
    if (rdy && q_data.size() > 0) begin
      void'(q_data.pop_front());
      void'(q_chan.pop_front());
    end
    if (psh) begin
      if (q_data.size() < 2) begin q_data.push_back(pw); q_chan.push_back(pc); end
      else oset = 1;
    end
    if (eset) m_ferr = 1; else if (clr) m_ferr = 0;
    if (oset) m_ovf = 1;  else if (clr) m_ovf = 0;
  endtask

  task automatic check_outputs();
    chk("valid", 32'(pcm_valid), 32'(q_data.size() > 0));
    if (q_data.size() > 0) begin
      chk("data", 32'(pcm_data), q_data[0]);
      chk("chan", 32'(pcm_chan), q_chan[0]);
    end
    chk("frame_err", 32'(frame_err), 32'(m_ferr));
    chk("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(pcm_valid), 0);
    chk({tag, "_data"}, 32'(pcm_data), 0);
    chk({tag, "_chan"}, 32'(pcm_chan), 0);
    chk({tag, "_ferr"}, 32'(frame_err), 0);
    chk({tag, "_ovf"}, 32'(ovf), 0);
    chk({tag, "_scan"}, 32'({scan_out0, scan_out1, scan_out2, scan_out3, scan_out4}), 0);
  endtask

  function automatic logic rdy_now();
    if (rdy_mode == 0) return 1'b1;
    if (rdy_mode == 1) return 1'b0;
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock: drive, compare at the falling edge, advance the model.
  task automatic step(input logic ben, din, fs, rdy, clr);
    tdm_ben = ben; tdm_din = din; tdm_fs = fs; pcm_ready = rdy; err_clr = clr;
    @(negedge clk);
    check_outputs();
    if (rdy && q_data.size() > 0) pops++;
    model_update(ben, din, fs, rdy, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic din, fs, clr);
    repeat ($urandom_range(0, gap_max))
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rdy_now(), 1'b0);
    step(1'b1, din, fs, rdy_now(), clr);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic fs_first);
    for (int b = W - 1; b >= 0; b--) ev(w[b], fs_first && (b == W - 1), 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, rdy_now(), 1'b0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all_zero("rst");
    @(posedge clk);
    #1 reset = 1'b1;
    pops = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] w3;
    reset = 1'b0;
    tdm_ben = 0; tdm_din = 0; tdm_fs = 0; pcm_ready = 0; err_clr = 0;
    scan_in0 = 0; scan_in1 = 0; scan_in2 = 0; scan_in3 = 0; scan_in4 = 0;
    scan_enable = 0; test_mode = 0;
    model_reset();
    #12;
    check_all_zero("por");
    @(posedge clk);
    #1 reset = 1'b1;

    // Clean frame followed by the next frame's sync.
    rdy_mode = 0; gap_max = 1; pops = 0;
    for (int k = 0; k < NCH; k++) send_word(8'hA0 + 8'(k), k == 0);
    idle(3);
    chk("clean_pops", pops, 32);
    chk("clean_ferr", 32'(frame_err), 0);
    chk("clean_ovf", 32'(ovf), 0);
    send_word(8'h5A, 1'b1);
    idle(2);
    chk("clean_next_pops", pops, 33);
    chk("clean_next_ferr", 32'(frame_err), 0);

    // Backpressure: third word dropped, then drain and clear.
    do_reset();
    rdy_mode = 1; gap_max = 0;
    send_word(8'h11, 1'b1);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b0);
    idle(1);
    chk("bp_ovf", 32'(ovf), 1);
    chk("bp_head", 32'(pcm_data), 32'h11);
    rdy_mode = 0;
    idle(3);
    chk("bp_pops", pops, 2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("bp_clr", 32'(ovf), 0);

    // Full buffer, pop in the same cycle as the completing push.
    do_reset();
    rdy_mode = 1; gap_max = 0;
    send_word(8'h01, 1'b1);
    send_word(8'h02, 1'b0);
    w3 = 8'h03;
    for (int b = W - 1; b >= 1; b--) ev(w3[b], 1'b0, 1'b0);
    rdy_mode = 0;
    ev(w3[0], 1'b0, 1'b0);
    chk("race_ovf", 32'(ovf), 0);
    idle(4);
    chk("race_pops", pops, 3);

    // Early frame sync inside slot 5.
    do_reset();
    rdy_mode = 0; gap_max = 1;
    for (int k = 0; k < 5; k++) send_word(8'(k + 1), k == 0);
    ev(1'b1, 1'b0, 1'b0); ev(1'b0, 1'b0, 1'b0); ev(1'b1, 1'b0, 1'b0);
    ev(1'b1, 1'b1, 1'b0);
    chk("early_ferr", 32'(frame_err), 1);
    for (int b = W - 2; b >= 0; b--) ev(1'b0, 1'b0, 1'b0);
    chk("early_chan", 32'(pcm_chan), 0);
    chk("early_data", 32'(pcm_data), 32'h80);
    idle(2);

    // Missing sync after slot 31, cleared in the same cycle it is set.
    do_reset();
    rdy_mode = 2; gap_max = 1;
    for (int k = 0; k < NCH; k++) send_word(8'($urandom), k == 0);
    ev(1'b1, 1'b0, 1'b1);
    chk("miss_ferr", 32'(frame_err), 1);
    rdy_mode = 0;
    idle(4);
    pops = 0;
    for (int i = 0; i < 20; i++) ev(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    idle(2);
    chk("miss_hunt_pops", pops, 0);
    send_word(8'hC3, 1'b1);
    idle(2);
    chk("miss_resync_pops", pops, 1);

    // Reset in the middle of slot 10 with a full buffer.
    do_reset();
    rdy_mode = 1; gap_max = 0;
    for (int k = 0; k < 10; k++) send_word(8'(k + 8'h40), k == 0);
    ev(1'b1, 1'b0, 1'b0); ev(1'b0, 1'b0, 1'b0); ev(1'b1, 1'b0, 1'b0);
    chk("mid_valid", 32'(pcm_valid), 1);
    do_reset();
    rdy_mode = 0;
    for (int i = 0; i < 24; i++) ev(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    idle(2);
    chk("mid_nofs_pops", pops, 0);

    // Random frames, random backpressure, sporadic bad syncs and clears.
    do_reset();
    rdy_mode = 2; gap_max = 2;
    for (int i = 0; i < 6 * NCH * W; i++)
      ev(1'($urandom_range(0, 1)),
         1'((i % (NCH * W) == 0) || ($urandom_range(0, 399) == 0)),
         1'($urandom_range(0, 63) == 0));
    rdy_mode = 0;
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
